// File: rtl/ycbcr2rgb_stream_pkg.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_stream_pkg
// Shared constants for the full-range BT.601 YCbCr-to-RGB stream converter:
// Q8 signed conversion coefficients, the rounding constant, the chroma offset,
// internal datapath widths and the default frame dimensions.
// ---------------------------------------------------------------------------
package ycbcr2rgb_stream_pkg;

    // Datapath widths
    localparam int CHROMA_W = 9;   // Cb/Cr after offset removal, signed
    localparam int LUMA_W   = 10;  // Y zero-extended into a signed field
    localparam int PROD_W   = 18;  // coefficient x chroma products
    localparam int SUM_W    = 11;  // per-channel result before clamping

    // Q8 coefficients (value * 256)
    localparam logic signed [PROD_W-1:0] KR  = 18'sd359;
    localparam logic signed [PROD_W-1:0] KGB = 18'sd88;
    localparam logic signed [PROD_W-1:0] KGR = 18'sd183;
    localparam logic signed [PROD_W-1:0] KB  = 18'sd454;

    // Half an LSB of the Q8 product, added before the floor shift
    localparam logic signed [PROD_W-1:0] ROUND_Q8 = 18'sd128;

    // Chroma channels are carried with a +128 offset
    localparam logic signed [CHROMA_W-1:0] CHROMA_OFS = 9'sd128;

    // Default frame geometry
    localparam int DEF_WIDTH  = 500;
    localparam int DEF_HEIGHT = 500;

endpackage

// File: rtl/ycbcr2rgb_stream_if.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_stream_if
// Pixel stream bundle for the YCbCr-to-RGB converter.
//   in_valid/in_ready   : input handshake
//   in_y/in_cb/in_cr    : 8-bit luma and offset chroma
//   out_valid/out_ready : output handshake
//   out_r/out_g/out_b   : 8-bit RGB result
//   out_eol/out_eof     : raster flags qualifying out_valid
//   frame_done          : one-cycle pulse after the eof pixel is taken
// Modports: slave = converter side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface ycbcr2rgb_stream_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [7:0] in_cb;
    logic [7:0] in_cr;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic       out_eol;
    logic       out_eof;
    logic       frame_done;

    modport slave (
        input  in_valid, in_y, in_cb, in_cr, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b,
               out_eol, out_eof, frame_done
    );

    modport master (
        output in_valid, in_y, in_cb, in_cr, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b,
               out_eol, out_eof, frame_done
    );

endinterface

// File: rtl/ycbcr2rgb_stream_clamp.sv
// ---------------------------------------------------------------------------
// ycc2rgb_clamp
// Reduces one 11-bit signed channel result to an 8-bit pixel value.
//   din  : 11-bit signed channel value
//   dout : 8-bit channel value
// Build option: YCC2RGB_SAT_EN defined -> clamp to [0,255];
//               undefined              -> keep the low 8 bits (wrap).
// ---------------------------------------------------------------------------
module ycc2rgb_clamp
    import ycbcr2rgb_stream_pkg::*;
(
    input  logic signed [SUM_W-1:0] din,
    output logic        [7:0]       dout
);

`ifdef YCC2RGB_SAT_EN
    always_comb begin
        // NOTE: dout gets a value on every path (default first), so no latch is inferred.
        dout = din[7:0];
        if (din < 11'sd0) begin
            dout = 8'd0;
        end else if (din > 11'sd255) begin
            dout = 8'd255;
        end
    end
`else
    // The upper bits are deliberately discarded in the wrapping build.
    logic unused_hi;
    assign unused_hi = ^din[SUM_W-1:8];

    always_comb begin
        dout = din[7:0];
    end
`endif

endmodule

// File: rtl/ycbcr2rgb_stream.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_stream
// Streaming full-range BT.601 YCbCr-to-RGB converter with raster flags.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ycbcr2rgb_stream_if.slave (input/output handshakes, pixel data,
//          out_eol/out_eof position flags, frame_done pulse)
// Parameters: WIDTH x HEIGHT frame geometry.
// Pipeline: s1 offset removal -> s2 products -> s3 channel sums -> output
// register (clamped), so a pixel taken at edge N is presented after edge N+3.
// The whole pipeline advances together whenever the output slot is free or
// being drained; bubbles travel through as invalid stages.
// Build option: YCC2RGB_SAT_EN selects saturating channel outputs.
// ---------------------------------------------------------------------------
module ycbcr2rgb_stream
    import ycbcr2rgb_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    ycbcr2rgb_stream_if.slave  bus
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    // Handshake
    logic en;
    logic out_acc;

    // Stage 1: offset-free chroma, luma widened
    logic                       v1;
    logic signed [LUMA_W-1:0]   y1;
    logic signed [CHROMA_W-1:0] cb1;
    logic signed [CHROMA_W-1:0] cr1;

    // Stage 2: products
    logic                       v2;
    logic signed [LUMA_W-1:0]   y2;
    logic signed [PROD_W-1:0]   p_r;
    logic signed [PROD_W-1:0]   p_gb;
    logic signed [PROD_W-1:0]   p_gr;
    logic signed [PROD_W-1:0]   p_b;

    // Stage 3: unclamped channel results
    logic                       v3;
    logic signed [SUM_W-1:0]    r3;
    logic signed [SUM_W-1:0]    g3;
    logic signed [SUM_W-1:0]    b3;
    logic signed [SUM_W-1:0]    r_sum;
    logic signed [SUM_W-1:0]    g_sum;
    logic signed [SUM_W-1:0]    b_sum;

    // Output register
    logic                       out_valid_q;
    logic [7:0]                 out_r_q;
    logic [7:0]                 out_g_q;
    logic [7:0]                 out_b_q;
    logic [7:0]                 r_c;
    logic [7:0]                 g_c;
    logic [7:0]                 b_c;

    // Raster position of the pixel currently presented
    logic [XW-1:0]              x_cnt;
    logic [YW-1:0]              y_cnt;
    logic                       eol;
    logic                       eof;
    logic                       frame_done_q;

    assign en      = !out_valid_q || bus.out_ready;
    assign out_acc = out_valid_q && bus.out_ready;

    // ---- stage 3 arithmetic: floor(x + 128) / 256, then add/sub luma ----
    always_comb begin
        r_sum = SUM_W'(PROD_W'(y2) + ((p_r + ROUND_Q8) >>> 8));
        g_sum = SUM_W'(PROD_W'(y2) - ((p_gb + p_gr + ROUND_Q8) >>> 8));
        b_sum = SUM_W'(PROD_W'(y2) + ((p_b + ROUND_Q8) >>> 8));
    end

    ycc2rgb_clamp u_clamp_r (.din(r3), .dout(r_c));
    ycc2rgb_clamp u_clamp_g (.din(g3), .dout(g_c));
    ycc2rgb_clamp u_clamp_b (.din(b3), .dout(b_c));

    // ---- pipeline: every stage moves only when the output can advance ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            y1          <= '0;
            cb1         <= '0;
            cr1         <= '0;
            v2          <= 1'b0;
            y2          <= '0;
            p_r         <= '0;
            p_gb        <= '0;
            p_gr        <= '0;
            p_b         <= '0;
            v3          <= 1'b0;
            r3          <= '0;
            g3          <= '0;
            b3          <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage read the value its
            // predecessor held before this edge, which is what makes it a pipeline.
            v1          <= bus.in_valid;
            y1          <= $signed({2'b00, bus.in_y});
            cb1         <= $signed({1'b0, bus.in_cb}) - CHROMA_OFS;
            cr1         <= $signed({1'b0, bus.in_cr}) - CHROMA_OFS;

            v2          <= v1;
            y2          <= y1;
            p_r         <= KR  * PROD_W'(cr1);
            p_gb        <= KGB * PROD_W'(cb1);
            p_gr        <= KGR * PROD_W'(cr1);
            p_b         <= KB  * PROD_W'(cb1);

            v3          <= v2;
            r3          <= r_sum;
            g3          <= g_sum;
            b3          <= b_sum;

            out_valid_q <= v3;
            out_r_q     <= r_c;
            out_g_q     <= g_c;
            out_b_q     <= b_c;
        end
    end

    // ---- raster position: moves only when an output pixel is taken ----
    assign eol = out_valid_q && (x_cnt == XW'(WIDTH - 1));
    assign eof = eol && (y_cnt == YW'(HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_acc && eof;
            if (out_acc) begin
                if (eol) begin
                    x_cnt <= '0;
                    y_cnt <= eof ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_r      = out_r_q;
    assign bus.out_g      = out_g_q;
    assign bus.out_b      = out_b_q;
    assign bus.out_eol    = eol;
    assign bus.out_eof    = eof;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ycbcr2rgb_stream.sv
// ---------------------------------------------------------------------------
// tb_ycbcr2rgb_stream
// Self-checking bench for ycbcr2rgb_stream on a 4x2 frame. A negedge monitor
// holds a reference model (BT.601 formulas in plain integer arithmetic) and a
// queue of expected pixels; it also tracks the expected raster position and
// the frame_done pulse. Directed steps cover reset, frame flags, fixed
// vectors with latency, back-pressure, random traffic and mid-frame reset.
// Honours YCC2RGB_SAT_EN in the expected values.
// ---------------------------------------------------------------------------
module tb_ycbcr2rgb_stream;

    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ycbcr2rgb_stream_if bus ();

    ycbcr2rgb_stream #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fail(input string tag);
        n_checks++;
        $error("FAIL %s: bound expired", tag);
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div256(input int v);
        return (v >= 0) ? (v / 256) : -((-v + 255) / 256);
    endfunction

    function automatic logic [7:0] to_pixel(input int v);
`ifdef YCC2RGB_SAT_EN
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
`else
        return 8'(((v % 256) + 256) % 256);
`endif
    endfunction

    function automatic logic [23:0] model(input int y, input int cb, input int cr);
        int cbs = cb - 128;
        int crs = cr - 128;
        int r   = y + floor_div256(359 * crs + 128);
        int g   = y - floor_div256(88 * cbs + 183 * crs + 128);
        int b   = y + floor_div256(454 * cbs + 128);
        return {to_pixel(r), to_pixel(g), to_pixel(b)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [23:0] exp_q[$];
    int          idx     = 0;   // expected raster index of the presented pixel
    logic        fd_pend = 1'b0;
    int          out_cnt = 0;
    int          eol_cnt = 0;
    int          eof_cnt = 0;
    int          fd_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            idx     = 0;
            fd_pend = 1'b0;
        end else begin
            chk("frame_done", bus.frame_done, fd_pend);
            if (bus.frame_done) fd_cnt++;
            fd_pend = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    logic [23:0] e;
                    logic        e_eol;
                    logic        e_eof;
                    e     = exp_q.pop_front();
                    e_eol = ((idx % W) == W - 1);
                    e_eof = (idx == W * H - 1);
                    chk("rgb", {bus.out_r, bus.out_g, bus.out_b}, e);
                    chk("eol", bus.out_eol, e_eol);
                    chk("eof", bus.out_eof, e_eof);
                    if (bus.out_eol) eol_cnt++;
                    if (bus.out_eof) eof_cnt++;
                    fd_pend = e_eof;
                    idx     = (idx + 1) % (W * H);
                    out_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_y, bus.in_cb, bus.in_cr));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        bus.in_valid = 1'b1;
        bus.in_y     = y;
        bus.in_cb    = cb;
        bus.in_cr    = cr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail("send_timeout");
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                return;
            end
            @(posedge clk);
        end
        fail("wait_valid_timeout");
    endtask

    task automatic drain();
        bit done = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail("drain_timeout");
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic one_pixel(input string tag, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input logic [23:0] exp_rgb);
        int lat;
        send(y, cb, cr);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_rgb"}, {bus.out_r, bus.out_g, bus.out_b}, exp_rgb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_eol;
        int base_eof;
        int base_fd;
        int base_out;
        int lat;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_y      = '0;
        bus.in_cb     = '0;
        bus.in_cr     = '0;
        bus.out_ready = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_rgb", {bus.out_r, bus.out_g, bus.out_b}, 24'h0);
        chk("rst_eol", bus.out_eol, 1'b0);
        chk("rst_eof", bus.out_eof, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // ---- two frames back to back: eol/eof/frame_done ----
        for (int i = 0; i < 2 * W * H; i++)
            send(8'($urandom), 8'($urandom), 8'($urandom));
        drain();
        chk("frame_out_cnt", out_cnt, 2 * W * H);
        chk("frame_eol_cnt", eol_cnt, 4);
        chk("frame_eof_cnt", eof_cnt, 2);
        chk("frame_fd_cnt", fd_cnt, 2);

        // ---- fixed vectors with latency ----
        one_pixel("grey", 8'd128, 8'd128, 8'd128, {8'd128, 8'd128, 8'd128});
`ifdef YCC2RGB_SAT_EN
        one_pixel("hi_cr", 8'd255, 8'd128, 8'd255, {8'd255, 8'd164, 8'd255});
        one_pixel("zero",  8'd0,   8'd0,   8'd0,   {8'd0,   8'd135, 8'd0});
`else
        one_pixel("hi_cr", 8'd255, 8'd128, 8'd255, {8'd177, 8'd164, 8'd255});
        one_pixel("zero",  8'd0,   8'd0,   8'd0,   {8'd77,  8'd135, 8'd29});
`endif
        drain();

        // ---- back-pressure with full pipeline ----
        base_out      = out_cnt;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 8'd128, 8'd128);
        bus.in_y = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_hold_rgb", {bus.out_r, bus.out_g, bus.out_b}, {8'd1, 8'd1, 8'd1});
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 5; i <= 10; i++) send(8'(i), 8'd128, 8'd128);
        drain();
        chk("bp_out_cnt", out_cnt - base_out, 10);

        // ---- random traffic with random back-pressure ----
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_y      = 8'($urandom);
            bus.in_cb     = 8'($urandom);
            bus.in_cr     = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // ---- reset after 3 pixels of a line ----
        n = (3 - (idx % W) + W) % W;
        for (int i = 0; i < n; i++) send(8'($urandom), 8'($urandom), 8'($urandom));
        drain();
        bus.out_ready = 1'b0;
        send(8'd10, 8'd20, 8'd30);
        send(8'd40, 8'd50, 8'd60);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_eol", bus.out_eol, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_eol", bus.out_eol, 1'b0);
        chk("async_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base_eol      = eol_cnt;
        base_eof      = eof_cnt;
        base_fd       = fd_cnt;
        bus.out_ready = 1'b1;
        send(8'd99, 8'd128, 8'd128);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_first_eol", bus.out_eol, 1'b0);
        chk("post_rst_first_eof", bus.out_eof, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 8'($urandom));
        drain();
        chk("post_rst_eol_cnt", eol_cnt - base_eol, 1);
        chk("post_rst_eof_cnt", eof_cnt - base_eof, 0);
        chk("post_rst_fd_cnt", fd_cnt - base_fd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
